quant_rle_serializer: RTL and testbench

//  Consumer of the DCT/quantizer block. Captures one 8x8 quantized block from the

---
 rtl/quant_rle_serializer_pkg.sv | 36 +++
 rtl/quant_rle_serializer_zigzag_lut.sv | 11 +
 rtl/quant_rle_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_quant_rle_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_rle_serializer_pkg.sv
// Shared definitions for the quantized-block RLE serializer: sizes, the JPEG
// zigzag scan table, the ZRL run value and the FSM state encoding.
package quant_rle_serializer_pkg;

  localparam int DEF_COEF_W = 8;
  localparam int DEF_N_COEF = 64;
  localparam int ZZ_W       = 6;

  // Run value carried by a ZRL symbol (sixteen consecutive zeros).
  localparam logic [3:0] ZRL_RUN = 4'd15;

  // Zigzag scan position -> raster position (r*8+c).
  localparam logic [ZZ_W-1:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DC,
    S_AC,
    S_EOB
  } state_t;

  function automatic logic [ZZ_W-1:0] zz_to_raster(input logic [ZZ_W-1:0] zz);
    return ZZ_TABLE[zz];
  endfunction

endpackage

// File: rtl/quant_rle_serializer_zigzag_lut.sv
// Combinational zigzag lookup: scan position -> raster coefficient position.
module quant_rle_serializer_zigzag_lut
  import quant_rle_serializer_pkg::*;
(
  input  logic [ZZ_W-1:0] zz_idx_i,
  output logic [ZZ_W-1:0] raster_idx_o
);

  assign raster_idx_o = zz_to_raster(zz_idx_i);

endmodule

// File: rtl/quant_rle_serializer.sv
// Captures one 8x8 quantized block, scans it in zigzag order and emits
// DC-difference, (run,level), ZRL and EOB symbols over a valid/ready stream.
module quant_rle_serializer
  import quant_rle_serializer_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int N_COEF = DEF_N_COEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable2_i,
  input  logic [N_COEF*COEF_W-1:0] quantized_flat_i,
  output logic                     in_ready_o,
  output logic                     overflow_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_dc_o,
  output logic [3:0]               out_run_o,
  output logic [COEF_W:0]          out_level_o,
  output logic                     out_eob_o,
  output logic                     out_last_o
);

  localparam int LVL_W = COEF_W + 1;

  state_t                     state_q, state_d;
  logic                       enable2_q;
  logic                       rise;
  logic [N_COEF*COEF_W-1:0]   blk_q, blk_d;
  logic [ZZ_W-1:0]            last_nz_q, last_nz_d;
  logic [ZZ_W:0]              idx_q, idx_d;      // one extra bit to step past 63
  logic [3:0]                 run_q, run_d;
  logic [COEF_W-1:0]          dc_pred_q, dc_pred_d;
  logic                       overflow_q, overflow_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_dc_q, out_dc_d;
  logic [3:0]                 out_run_q, out_run_d;
  logic [LVL_W-1:0]           out_level_q, out_level_d;
  logic                       out_eob_q, out_eob_d;
  logic                       out_last_q, out_last_d;

  logic [COEF_W-1:0]          coef [N_COEF];
  logic [63:1]                nz_zz;
  logic [ZZ_W-1:0]            last_nz_calc;
  logic [ZZ_W-1:0]            ac_raster;
  logic [COEF_W-1:0]          ac_coef;
  logic [LVL_W-1:0]           dc_diff;
  logic                       can_load;

  assign rise = enable2_i & ~enable2_q;

  // Slice the captured block into raster-ordered coefficients.
  for (genvar gi = 0; gi < N_COEF; gi++) begin : g_coef
    assign coef[gi] = blk_q[gi*COEF_W +: COEF_W];
  end

  // Nonzero flags in zigzag order (AC positions only).
  for (genvar gi = 1; gi < 64; gi++) begin : g_nz
    assign nz_zz[gi] = |coef[ZZ_TABLE[gi]];
  end

  // Highest zigzag position holding a nonzero AC coefficient (0 if none).
  always_comb begin
    last_nz_calc = '0;
    for (int i = 1; i < 64; i++) begin
      if (nz_zz[i]) last_nz_calc = ZZ_W'(i);
    end
  end

  quant_rle_serializer_zigzag_lut u_zigzag_lut (
    .zz_idx_i     (idx_q[ZZ_W-1:0]),
    .raster_idx_o (ac_raster)
  );

  assign ac_coef = coef[ac_raster];
  assign dc_diff = {coef[0][COEF_W-1], coef[0]} - {dc_pred_q[COEF_W-1], dc_pred_q};

  // The output register may take a new symbol when empty or being drained.
  assign can_load = ~out_valid_q | out_ready_i;

  // Next-state, scan and symbol-formation logic.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    last_nz_d   = last_nz_q;
    idx_d       = idx_q;
    run_d       = run_q;
    dc_pred_d   = dc_pred_q;
    overflow_d  = overflow_q | (rise & (state_q != S_IDLE));
    out_valid_d = out_valid_q & ~out_ready_i;
    out_dc_d    = out_dc_q;
    out_run_d   = out_run_q;
    out_level_d = out_level_q;
    out_eob_d   = out_eob_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          blk_d   = quantized_flat_i;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        last_nz_d = last_nz_calc;
        idx_d     = (ZZ_W+1)'(1);
        run_d     = '0;
        state_d   = S_DC;
      end

      S_DC: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_dc_d    = 1'b1;
          out_run_d   = '0;
          out_level_d = dc_diff;
          out_eob_d   = 1'b0;
          out_last_d  = 1'b0;
          dc_pred_d   = coef[0];
          state_d     = S_AC;
        end
      end

      S_AC: begin
        if (idx_q > {1'b0, last_nz_q}) begin
          // Scan finished; a full block ends once its last symbol is drained.
          if (last_nz_q == ZZ_W'(63)) begin
            if (can_load) state_d = S_IDLE;
          end else begin
            state_d = S_EOB;
          end
        end else if (can_load) begin
          if (ac_coef != '0) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b0;
            out_run_d   = run_q;
            out_level_d = {ac_coef[COEF_W-1], ac_coef};
            out_eob_d   = 1'b0;
            out_last_d  = (idx_q == (ZZ_W+1)'(63));
            run_d       = '0;
          end else if (run_q == ZRL_RUN) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b0;
            out_run_d   = ZRL_RUN;
            out_level_d = '0;
            out_eob_d   = 1'b0;
            out_last_d  = 1'b0;
            run_d       = '0;
          end else begin
            run_d = run_q + 4'd1;
          end
          idx_d = idx_q + (ZZ_W+1)'(1);
        end
      end

      S_EOB: begin
        if (out_valid_q && out_eob_q) begin
          if (out_ready_i) state_d = S_IDLE;
        end else if (can_load) begin
          out_valid_d = 1'b1;
          out_dc_d    = 1'b0;
          out_run_d   = '0;
          out_level_d = '0;
          out_eob_d   = 1'b1;
          out_last_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath, predictor and output-symbol registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable2_q   <= 1'b0;
      blk_q       <= '0;
      last_nz_q   <= '0;
      idx_q       <= '0;
      run_q       <= '0;
      dc_pred_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dc_q    <= 1'b0;
      out_run_q   <= '0;
      out_level_q <= '0;
      out_eob_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      enable2_q   <= enable2_i;
      blk_q       <= blk_d;
      last_nz_q   <= last_nz_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      dc_pred_q   <= dc_pred_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_dc_q    <= out_dc_d;
      out_run_q   <= out_run_d;
      out_level_q <= out_level_d;
      out_eob_q   <= out_eob_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign overflow_o  = overflow_q;
  assign out_valid_o = out_valid_q;
  assign out_dc_o    = out_dc_q;
  assign out_run_o   = out_run_q;
  assign out_level_o = out_level_q;
  assign out_eob_o   = out_eob_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_quant_rle_serializer.sv
// Directed bench for quant_rle_serializer: symbol sequences, latency, stalls,
// overflow and mid-block reset.
module tb_quant_rle_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable2;
  logic [511:0] quantized_flat;
  logic         in_ready;
  logic         overflow;
  logic         out_valid;
  logic         out_ready;
  logic         out_dc;
  logic [3:0]   out_run;
  logic [8:0]   out_level;
  logic         out_eob;
  logic         out_last;

  always #5 clk = ~clk;

  quant_rle_serializer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable2_i        (enable2),
    .quantized_flat_i (quantized_flat),
    .in_ready_o       (in_ready),
    .overflow_o       (overflow),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_dc_o         (out_dc),
    .out_run_o        (out_run),
    .out_level_o      (out_level),
    .out_eob_o        (out_eob),
    .out_last_o       (out_last)
  );

  typedef logic [15:0] sym_t;

  sym_t        got_q[$];
  sym_t        exp_q[$];
  logic signed [7:0] blk_tb [64];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          stall_err = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  sym_t        stall_sym = '0;
  logic        t5_run;

  function automatic sym_t mk(input bit dc, input int run, input int lvl,
                              input bit eob, input bit last);
    logic [3:0] r;
    logic [8:0] l;
    r = 4'(run);
    l = 9'(lvl);
    return {dc, r, l, eob, last};
  endfunction

  function automatic sym_t dut_sym();
    return {out_dc, out_run, out_level, out_eob, out_last};
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Collect accepted symbols and watch stalled symbols for stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          stall_cnt++;
          if (dut_sym() != stall_sym) stall_err++;
        end
        if (out_valid && out_ready) got_q.push_back(dut_sym());
        prev_stall = out_valid && !out_ready;
        stall_sym  = dut_sym();
      end
    end
  end

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk_tb[i] = '0;
  endtask

  task automatic drive_flat();
    for (int i = 0; i < 64; i++) quantized_flat[i*8 +: 8] = blk_tb[i];
  endtask

  task automatic send_block();
    @(posedge clk);
    #1;
    drive_flat();
    enable2 = 1'b1;
    @(posedge clk);
    #1;
    enable2 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !out_valid) done = 1'b1;
    end
    check({tag, "_done"}, int'(done), 1);
  endtask

  task automatic compare_seq(input string tag);
    int n;
    check({tag, "_nsym"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_sym%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic load_t2_block();
    clear_blk();
    blk_tb[0] = 8'sd10;
    blk_tb[1] = -8'sd3;
    blk_tb[8] = 8'sd5;
  endtask

  task automatic exp_t2(input int dc);
    exp_q.push_back(mk(1, 0, dc, 0, 0));
    exp_q.push_back(mk(0, 0, -3, 0, 0));
    exp_q.push_back(mk(0, 0, 5, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 1));
  endtask

  initial begin
    int  n;
    bit  found;

    rst_n          = 1'b0;
    enable2        = 1'b0;
    out_ready      = 1'b1;
    quantized_flat = '0;
    clear_blk();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_level", int'(out_level), 0);
    check("rst_last", int'(out_last), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // T1: all-zero block, latency from rise to DC valid.
    clear_blk();
    @(posedge clk);
    #1;
    drive_flat();
    enable2 = 1'b1;
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      n++;
      #1;
      enable2 = 1'b0;
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check("t1_latency", n, 3);
    wait_done("t1");
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    compare_seq("t1");

    // T2: two identical blocks; second DC difference is zero.
    load_t2_block();
    send_block();
    wait_done("t2a");
    exp_t2(10);
    compare_seq("t2a");
    send_block();
    wait_done("t2b");
    exp_t2(0);
    compare_seq("t2b");

    // T3: single 7 at zigzag 40 (raster 29): two ZRLs then run 7.
    clear_blk();
    blk_tb[29] = 8'sd7;
    send_block();
    wait_done("t3");
    exp_q.push_back(mk(1, 0, -10, 0, 0));
    exp_q.push_back(mk(0, 15, 0, 0, 0));
    exp_q.push_back(mk(0, 15, 0, 0, 0));
    exp_q.push_back(mk(0, 7, 7, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    compare_seq("t3");

    // T4: all ones; 63 AC symbols, last flagged, no EOB.
    for (int i = 0; i < 64; i++) blk_tb[i] = 8'sd1;
    send_block();
    wait_done("t4");
    exp_q.push_back(mk(1, 0, 1, 0, 0));
    for (int i = 1; i < 64; i++) exp_q.push_back(mk(0, 0, 1, 0, (i == 63)));
    compare_seq("t4");
    check("t4_in_ready", int'(in_ready), 1);

    // T5: T2 block under 1-on/2-off backpressure, plus a rise while busy.
    check("t5_overflow_before", int'(overflow), 0);
    load_t2_block();
    stall_err = 0;
    stall_cnt = 0;
    t5_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 3000 && t5_run; k++) begin
          @(posedge clk);
          #1;
          out_ready = (k % 3 == 0);
        end
        out_ready = 1'b1;
      end
      begin
        send_block();
        repeat (4) @(posedge clk);
        #1;
        clear_blk();
        drive_flat();
        enable2 = 1'b1;
        @(posedge clk);
        #1;
        enable2 = 1'b0;
        wait_done("t5");
        t5_run = 1'b0;
      end
    join
    exp_t2(9);
    compare_seq("t5");
    check("t5_overflow", int'(overflow), 1);
    check("t5_stall_seen", int'(stall_cnt > 0), 1);
    check("t5_stall_stable", stall_err, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_dropped_block", got_q.size(), 0);

    // T6: asynchronous reset during the AC scan.
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) blk_tb[i] = 8'sd1;
    send_block();
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    check("t6_rst_overflow", int'(overflow), 0);
    check("t6_rst_level", int'(out_level), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    load_t2_block();
    send_block();
    wait_done("t6");
    exp_t2(10);
    compare_seq("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
